conv_patch_fifo: RTL and testbench
==================================

# conv_patch_fifo

Parametrised circular FIFO that buffers complete convolution patches (D channels × F×F window, DATA_WIDTH bits per element) between the window generator and the convolution MAC array. It stores a full DEPTH entries, accepts a read and a write in the same cycle, and reports occupancy and almost-full for upstream back-pressure. A synchronous clear flushes the FIFO between feature maps without a reset.

## Interface
- DATA_WIDTH, 16, bits per element
- D, 3, input channels per patch
- F, 3, window edge; entry width W = D*F*F*DATA_WIDTH
- DEPTH, 256, entries; power of two, ≥ 2
- AFULL_THRESH, DEPTH-4, almost_full asserts when count ≥ this value; range 1..DEPTH
- A = log2(DEPTH), derived localparam

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous flush
- write  in  1  write request
- data_in  in  W  write data
- read  in  1  read request
- data_out  out  W  registered read data
- out_verify  out  1  data_out valid pulse
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_THRESH
- count  out  A+1  current occupancy
- overflow  out  1  sticky error flag (see Configuration)
- underflow  out  1  sticky error flag (see Configuration)

## Operation
- Storage: DEPTH×W memory. Write and read pointers are A+1 bits; the MSB is the wrap bit. Index = ptr[A-1:0]. The FIFO is full when indices are equal and wrap bits differ, and empty when both are equal. All DEPTH entries are usable.
- A write is accepted iff write && !full. An accepted write sets mem[wptr] ← data_in and increments wptr modulo 2^(A+1).
- A read is accepted iff read && !empty. An accepted read sets data_out ← mem[rptr], increments rptr, and sets out_verify = 1. Otherwise out_verify = 0 and data_out holds its value.
- When a write and a read are both accepted, both happen and count is unchanged.
- There is no bypass: a write to an empty FIFO is not readable in the same cycle, and a read while empty is rejected.
- A write while full is dropped. Memory, pointers and count are unchanged.
- count increments on a write-only cycle and decrements on a read-only cycle.
- full, empty and almost_full are decoded from registered count and are glitch-free.
- clear has priority over write and read. On clear, pointers go to 0, count to 0 and out_verify to 0. data_out and memory are unchanged. Sticky flags are also cleared.
- Reset values: wptr = rptr = 0, count = 0, data_out = 0, out_verify = 0, overflow = underflow = 0. After reset, empty = 1 and full = almost_full = 0.
- Reset asserted mid-operation discards all contents immediately, asynchronously.

## Timing
- Write accepted at edge N: count, empty and full update after edge N. The entry is readable by a read accepted at edge N+1.
- Read accepted at edge N: data_out and out_verify are valid for the cycle after edge N. Read latency is 1. out_verify is high for exactly one cycle per accepted read.
- Back-to-back reads give one word per cycle, in write order.
- Flag latency is 0 cycles after the edge that changes count. Upstream must sample full or almost_full before asserting write.

## Configuration
- Macro: CONV_PATCH_FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on write && full && !clear.
  - underflow sets on read && empty && !clear.
  - Both flags are sticky until reset or clear.
- Undefined: overflow and underflow are tied to 0 and no flag logic is generated. Data-path behaviour is identical in both builds.

## Test plan
Bench uses DEPTH=4, AFULL_THRESH=3, DATA_WIDTH=4, D=1, F=1.
- Reset, then idle → empty=1, full=0, count=0, data_out=0, out_verify=0.
- Write 0x1,0x2,0x3,0x4 on consecutive cycles:
  - almost_full rises after the 3rd write.
  - full=1 and count=4 after the 4th write.
  - A 5th write of 0x5 is dropped; overflow=1 if the macro is defined.
- From full, read 4 times → data_out is 0x1,0x2,0x3,0x4 on consecutive cycles with out_verify high for each. Then empty=1, and a 5th read gives out_verify=0, data_out holds 0x4, and underflow=1 if defined.
- Wrap-around: with count=2, apply simultaneous read+write for 6 cycles → count stays 2, output order is preserved across the pointer wrap, and full and empty stay 0.
- Write to empty with read in the same cycle → read rejected (out_verify=0), count=1. Read on the next cycle returns the written word.
- clear while count=3 and write=1 → next cycle count=0, empty=1, and flags are cleared. The write is discarded. Asserting reset mid-burst zeroes count and out_verify asynchronously.

Source files
------------

// File: rtl/conv_patch_fifo.sv
// conv_patch_fifo: circular FIFO holding complete convolution patches
// (D channels x FxF window, DATA_WIDTH bits per element) between the window
// generator and the MAC array. All DEPTH entries are usable; a read and a
// write may be accepted in the same cycle. Read data is registered (latency 1).
// Occupancy flags are registered from the next-state count, so they change
// on the same edge as count and never glitch.
//
// Optional feature macro: CONV_PATCH_FIFO_ERR_FLAGS_EN
//   defined   -> sticky overflow/underflow flags are generated
//   undefined -> overflow/underflow are tied low
module conv_patch_fifo #(
    parameter int DATA_WIDTH   = 16,
    parameter int D            = 3,
    parameter int F            = 3,
    parameter int DEPTH        = 256,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             write,
    input  logic [D*F*F*DATA_WIDTH-1:0]      data_in,
    input  logic                             read,
    output logic [D*F*F*DATA_WIDTH-1:0]      data_out,
    output logic                             out_verify,
    output logic                             full,
    output logic                             empty,
    output logic                             almost_full,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int W = D * F * F * DATA_WIDTH;
    localparam int A = $clog2(DEPTH);

    localparam logic [A:0] PTR_ONE   = (A+1)'(1);
    localparam logic [A:0] CNT_DEPTH = (A+1)'(DEPTH);
    localparam logic [A:0] CNT_AFULL = (A+1)'(AFULL_THRESH);

    logic [W-1:0] mem_q [DEPTH];

    logic [A:0]   wptr_q, wptr_d;
    logic [A:0]   rptr_q, rptr_d;
    logic [A:0]   count_q, count_d;
    logic [W-1:0] data_out_q;
    logic         out_verify_q;
    logic         full_q;
    logic         empty_q;
    logic         afull_q;
    logic         wr_en_s;
    logic         rd_en_s;

    // Accept decisions and next-state pointers/count; clear overrides everything.
    always_comb begin
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            wr_en_s = write && !full_q;
            rd_en_s = read && !empty_q;
            if (wr_en_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (rd_en_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_d = count_q + PTR_ONE;
                2'b01:   count_d = count_q - PTR_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Patch storage: written only on an accepted write, never reset or cleared.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wptr_q[A-1:0]] <= data_in;
        end
    end

    // Pointers, occupancy, registered read data and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            out_verify_q <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            afull_q      <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            out_verify_q <= rd_en_s;
            if (rd_en_s) begin
                data_out_q <= mem_q[rptr_q[A-1:0]];
            end
            full_q       <= (count_d == CNT_DEPTH);
            empty_q      <= (count_d == '0);
            afull_q      <= (count_d >= CNT_AFULL);
        end
    end

`ifdef CONV_PATCH_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags: latch rejected writes/reads until reset or clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (write && full_q);
            underflow_q <= underflow_q | (read && empty_q);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign data_out    = data_out_q;
    assign out_verify  = out_verify_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = afull_q;
    assign count       = count_q;

endmodule

// File: tb/tb_conv_patch_fifo.sv
// Self-checking bench for conv_patch_fifo (DEPTH=4, AFULL_THRESH=3, 4-bit words).
// Reference model: a queue of stored words plus sticky error bits. Expected read
// words go into a scoreboard queue that a negedge monitor drains whenever the
// DUT raises out_verify.
module tb_conv_patch_fifo;

    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic [3:0] data_out;
    logic       out_verify;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] model_q[$];
    logic [3:0] exp_q[$];
    logic [3:0] last_read = 4'h0;
    logic       last_acc_r = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    conv_patch_fifo #(
        .DATA_WIDTH  (DW),
        .D           (1),
        .F           (1),
        .DEPTH       (DEPTH),
        .AFULL_THRESH(AF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .write      (write),
        .data_in    (data_in),
        .read       (read),
        .data_out   (data_out),
        .out_verify (out_verify),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every out_verify pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && out_verify) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: out_verify with data %0d, no read pending", data_out);
            end else begin
                check("sb_data", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_state(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ":count"}, int'(count), sz);
        check({tag, ":empty"}, int'(empty), int'(sz == 0));
        check({tag, ":full"}, int'(full), int'(sz == DEPTH));
        check({tag, ":afull"}, int'(almost_full), int'(sz >= AF));
        check({tag, ":out_verify"}, int'(out_verify), int'(last_acc_r));
        check({tag, ":data_out"}, int'(data_out), int'(last_read));
`ifdef CONV_PATCH_FIFO_ERR_FLAGS_EN
        check({tag, ":overflow"}, int'(overflow), int'(m_ovf));
        check({tag, ":underflow"}, int'(underflow), int'(m_unf));
`else
        check({tag, ":overflow"}, int'(overflow), 0);
        check({tag, ":underflow"}, int'(underflow), 0);
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, then check.
    task automatic cycle(input string tag, input logic w, input logic [3:0] d,
                         input logic r, input logic c);
        bit acc_w;
        bit acc_r;
        write   = w;
        data_in = d;
        read    = r;
        clear   = c;
        @(posedge clk);
        acc_r = 1'b0;
        if (c) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            acc_w = w && (model_q.size() < DEPTH);
            acc_r = r && (model_q.size() > 0);
            if (w && !acc_w) m_ovf = 1'b1;
            if (r && !acc_r) m_unf = 1'b1;
            if (acc_r) begin
                last_read = model_q.pop_front();
                exp_q.push_back(last_read);
            end
            if (acc_w) model_q.push_back(d);
        end
        last_acc_r = acc_r;
        #1;
        check_state(tag);
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_state("reset_idle");

        // Fill to full, then one dropped write
        for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, 4'(i), 1'b0, 1'b0);
        cycle("write_when_full", 1'b1, 4'h5, 1'b0, 1'b0);

        // Drain, then one rejected read
        for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 4'h0, 1'b1, 1'b0);
        cycle("read_when_empty", 1'b0, 4'h0, 1'b1, 1'b0);

        // Clear sticky flags, then wrap-around with simultaneous read+write
        cycle("clear1", 1'b0, 4'h0, 1'b0, 1'b1);
        cycle("pre_wrap", 1'b1, 4'hA, 1'b0, 1'b0);
        cycle("pre_wrap", 1'b1, 4'hB, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle("wrap_rw", 1'b1, 4'(i + 6), 1'b1, 1'b0);

        // No bypass: write+read on empty, then read next cycle
        cycle("clear2", 1'b0, 4'h0, 1'b0, 1'b1);
        cycle("wr_rd_empty", 1'b1, 4'h9, 1'b1, 1'b0);
        cycle("rd_after", 1'b0, 4'h0, 1'b1, 1'b0);

        // Build count=3 with overflow set, then clear with write asserted
        for (int i = 0; i < 5; i++) cycle("refill", 1'b1, 4'(i + 2), 1'b0, 1'b0);
        cycle("read_one", 1'b0, 4'h0, 1'b1, 1'b0);
        cycle("clear_w_write", 1'b1, 4'hF, 1'b0, 1'b1);

        // Random traffic with occasional clear
        for (int i = 0; i < 200; i++) begin
            cycle("random", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset mid-burst
        cycle("burst", 1'b1, 4'h3, 1'b0, 1'b0);
        cycle("burst", 1'b1, 4'h7, 1'b0, 1'b0);
        cycle("burst_rd", 1'b1, 4'h8, 1'b1, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst:count", int'(count), 0);
        check("async_rst:out_verify", int'(out_verify), 0);
        check("async_rst:empty", int'(empty), 1);
        check("async_rst:data_out", int'(data_out), 0);
        model_q.delete();
        exp_q.delete();
        last_read  = 4'h0;
        last_acc_r = 1'b0;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
        write = 1'b0;
        read  = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            cycle("post_rst", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'b0);
        end
        cycle("idle_end", 1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
